// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART state encodings and bit-timing derivation (UART_RX_PARITY_EN adds PARITY)
package uart_defs;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } uart_state_e;
`endif

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with mid-bit and end-of-bit ticks
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 10,
  parameter int HALF_BIT     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign half_tick = enable && (cnt == CNT_W'(HALF_BIT - 1));
  assign full_tick = enable && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Wrapping at full_tick keeps every following sample a whole bit period apart.
  always_ff @(posedge clk) begin
    if (rst || clear || !enable || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8-bit UART receiver, 8N1 by default, even parity with UART_RX_PARITY_EN
module uart_rx_core
  import uart_defs::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] uart_rdata,
  output logic       uart_read_fin,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,output logic      parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);

  logic        rx_meta, rx_sync;
  uart_state_e state, state_next;
  logic        half_tick, full_tick, clear;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        break_hold;
  logic        clr_idx, load_bit, done_ok, done_bad;
`ifdef UART_RX_PARITY_EN
  logic        par_sample, par_bad;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .HALF_BIT    (HALF_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .enable   (state != ST_IDLE),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr_idx    = 1'b0;
    load_bit   = 1'b0;
    done_ok    = 1'b0;
    done_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state)
      // break_hold stops a line stuck low from re-triggering after its frame error
      ST_IDLE:  if (!rx_sync && !break_hold) state_next = ST_START;
      ST_START: if (half_tick) begin
        if (rx_sync) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DATA;
          clr_idx    = 1'b1;
        end
      end
      ST_DATA:  if (full_tick) begin
        load_bit = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_idx == 3'd7) state_next = ST_PARITY;
`else
        if (bit_idx == 3'd7) state_next = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (full_tick) begin
        par_sample = 1'b1;
        state_next = ST_STOP;
      end
`endif
      ST_STOP:  if (full_tick) begin
        state_next = ST_IDLE;
        done_ok    = rx_sync;
        done_bad   = !rx_sync;
      end
      default:  state_next = ST_IDLE;
    endcase
    clear = (state_next != state);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift         <= 8'h00;
      bit_idx       <= 3'd0;
      uart_rdata    <= 8'h00;
      uart_read_fin <= 1'b0;
      frame_err     <= 1'b0;
      break_hold    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      uart_read_fin <= 1'b0;
      frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err    <= 1'b0;
      if (clr_idx)    par_bad <= 1'b0;
      if (par_sample) par_bad <= (rx_sync != ^shift);
`endif
      if (clr_idx) bit_idx <= 3'd0;
      if (load_bit) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (done_ok) begin
        uart_rdata <= shift;
`ifdef UART_RX_PARITY_EN
        if (par_bad) parity_err    <= 1'b1;
        else         uart_read_fin <= 1'b1;
`else
        uart_read_fin <= 1'b1;
`endif
      end
      if (done_bad) begin
        frame_err  <= 1'b1;
        break_hold <= 1'b1;
      end else if (rx_sync) begin
        break_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core (UART_RX_PARITY_EN aware)
module tb_uart_rx_core;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] uart_rdata;
  logic       uart_read_fin, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_core #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .uart_rdata   (uart_rdata),
    .uart_read_fin(uart_read_fin),
    .frame_err    (frame_err),
    .busy         (busy)
`ifdef UART_RX_PARITY_EN
    ,.parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           vectors = 0;
  int           miscompares = 0;
  logic [15:0]  exp_q[$];
  logic [15:0]  obs_q[$];
  int unsigned  obs_cyc[$];
  logic [7:0]   model_rdata = 8'h00;
  logic         prev_fin = 1'b0;
  int unsigned  start_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Events: kind 1 = good byte, 2 = frame error, 3 = parity error; low byte = data.
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_read_fin && frame_err) check_eq("pulse_exclusive", 32'd1, 32'd0);
      if (uart_read_fin) begin
        check_eq("fin_one_cycle", {31'd0, prev_fin}, 32'd0);
        obs_q.push_back({8'd1, uart_rdata});
        obs_cyc.push_back(cyc);
      end
      if (frame_err) begin
        obs_q.push_back({8'd2, 8'd0});
        obs_cyc.push_back(cyc);
      end
`ifdef UART_RX_PARITY_EN
      if (parity_err) begin
        obs_q.push_back({8'd3, uart_rdata});
        obs_cyc.push_back(cyc);
      end
`endif
    end
    prev_fin <= uart_read_fin;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    if (!stop_ok) begin
      exp_q.push_back({8'd2, 8'd0});
    end else begin
      model_rdata = d;
`ifdef UART_RX_PARITY_EN
      exp_q.push_back({(par_ok ? 8'd1 : 8'd3), d});
`else
      exp_q.push_back({8'd1, d});
`endif
    end
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok);
`endif
    send_bit(stop_ok);
    rxd = 1'b1;
  endtask

  task automatic compare_events(input string tag);
    logic [15:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check_eq({tag, "_missing"}, 32'hFFFF, {16'd0, e});
      end else begin
        o = obs_q.pop_front();
        void'(obs_cyc.pop_front());
        check_eq({tag, "_event"}, {16'd0, o}, {16'd0, e});
      end
    end
    check_eq({tag, "_extra"}, obs_q.size(), 32'd0);
    obs_q.delete();
    obs_cyc.delete();
    check_eq({tag, "_rdata"}, {24'd0, uart_rdata}, {24'd0, model_rdata});
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int waited;
    logic [7:0] d;
    logic s, p;

    rst = 1'b1;
    tick(3);
    check_eq("reset_rdata", {24'd0, uart_rdata}, 32'd0);
    check_eq("reset_fin", {31'd0, uart_read_fin}, 32'd0);
    check_eq("reset_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Single good frame; stop-bit sample sits ~9.5 bit times after the start edge.
    send_frame(8'h55, 1'b1, 1'b1);
    tick(3);
    lat = (obs_cyc.size() > 0) ? int'(obs_cyc[0] - start_cyc) : -1;
    check_eq("latency_in_90_100", {31'd0, (lat >= 90 && lat <= 100)}, 32'd1);
    compare_events("frame_55");

    // Short glitch must be rejected.
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    waited = 0;
    while (busy && waited < 8) begin
      tick(1);
      waited++;
    end
    check_eq("glitch_busy_drop", {31'd0, busy}, 32'd0);
    tick(5);
    compare_events("glitch");

    send_frame(8'hA3, 1'b0, 1'b1);
    tick(5);
    compare_events("frame_err_a3");

    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    tick(5);
    compare_events("back_to_back");

    // Reset during data bit 4 of an abandoned frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b0;
    tick(5);
    rst = 1'b1;
    rxd = 1'b1;
    tick(1);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_rdata", {24'd0, uart_rdata}, 32'd0);
    tick(1);
    rst = 1'b0;
    model_rdata = 8'h00;
    check_eq("midrst_fin", {31'd0, uart_read_fin}, 32'd0);
    check_eq("midrst_ferr", {31'd0, frame_err}, 32'd0);
    tick(30);
    compare_events("mid_reset_idle");
    send_frame(8'h3C, 1'b1, 1'b1);
    tick(5);
    compare_events("after_reset_3c");

    // Break: line low for many frame times gives a single frame error.
    exp_q.push_back({8'd2, 8'd0});
    rxd = 1'b0;
    tick(CPB * 30);
    rxd = 1'b1;
    tick(CPB * 2);
    compare_events("break");
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(5);
    compare_events("after_break");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    tick(5);
    compare_events("parity_bad_07");
`endif

    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 3) != 0);
      send_frame(d, s, p);
      tick(s ? $urandom_range(0, 15) : $urandom_range(3, 15));
    end
    tick(20);
    compare_events("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
